// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared definitions for the transmit-frame arbiter.
//   arb_state_e     : arbiter FSM states
//   DEF_*           : default parameter values for N_REQ, FRAME_W, ACK_TIMEOUT
//   clog2()         : ceiling log2, minimum 1, usable in constant expressions
package tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_e;

  localparam int unsigned DEF_N_REQ       = 4;
  localparam int unsigned DEF_FRAME_W     = 9;
  localparam int unsigned DEF_ACK_TIMEOUT = 15;

  // Never returns 0 so that index fields stay at least one bit wide.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned k = 1; k < 32; k++) begin
      if ((32'd1 << k) < v) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority selector.
//   req_i   [N]  : request vector
//   ptr_i   [IW] : highest-priority index this cycle (must be < N)
//   idx_o   [IW] : first set request at or after ptr_i, wrapping N-1 -> 0
//   valid_o      : at least one request is set
module rr_picker
  import tx_arb_pkg::*;
#(
  parameter  int unsigned N  = DEF_N_REQ,
  localparam int unsigned IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    logic [IW:0] cand;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // One extra bit holds ptr+i (at most 2N-2) before the wrap subtraction.
      cand = {1'b0, ptr_i} + (IW+1)'(i);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!valid_o && req_i[cand[IW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin sharing of one frame transmitter among N_REQ
// sources. Latches the winning frame, strobes tx_send once, follows the
// transmitter ready/busy handshake and acks (or aborts on timeout) the source.
//   clk, rst         : clock, asynchronous active-high reset
//   req      [N]     : per-source request level
//   frame_in [N*FW]  : source i frame on [i*FW +: FW]
//   ack      [N]     : one-cycle completion pulse to the granted source
//   abort    [N]     : one-cycle timeout pulse to the granted source
//   tx_ready         : transmitter idle (1) / busy (0)
//   tx_send          : one-cycle send strobe
//   tx_frame [FW]    : latched frame, stable until the next grant
//   grant_id [IW]    : current/last granted source
//   busy             : arbiter not in IDLE
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter  int unsigned N_REQ       = DEF_N_REQ,
  parameter  int unsigned FRAME_W     = DEF_FRAME_W,
  parameter  int unsigned ACK_TIMEOUT = DEF_ACK_TIMEOUT,
  localparam int unsigned IDX_W       = clog2(N_REQ),
  localparam int unsigned CNT_W       = clog2(ACK_TIMEOUT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*FRAME_W-1:0]   frame_in,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           abort,
  input  logic                       tx_ready,
  output logic                       tx_send,
  output logic [FRAME_W-1:0]         tx_frame,
  output logic [IDX_W-1:0]           grant_id,
  output logic                       busy
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [N_REQ-1:0]   abort_q, abort_d;
  logic               send_q, send_d;
  logic               busy_q, busy_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [IDX_W-1:0]   next_ptr;
  logic [FRAME_W-1:0] frames [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign frames[g] = frame_in[g*FRAME_W +: FRAME_W];
  end

  rr_picker #(
    .N(N_REQ)
  ) u_picker (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign next_ptr = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

  // Outputs are registered from the next-state values, so the grant edge
  // already shows tx_send/busy/tx_frame/grant_id in the following cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    grant_d = grant_q;
    ack_d   = '0;
    abort_d = '0;
    send_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_ready && pick_valid) begin
          frame_d = frames[pick_idx];
          grant_d = pick_idx;
          send_d  = 1'b1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!tx_ready) begin
          state_d = WAIT_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_W'(ACK_TIMEOUT)) begin
            abort_d[grant_q] = 1'b1;
            ptr_d            = next_ptr;
            state_d          = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          ack_d[grant_q] = 1'b1;
          ptr_d          = next_ptr;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      frame_q <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      abort_q <= '0;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      abort_q <= abort_d;
      send_q  <= send_d;
      busy_q  <= busy_d;
    end
  end

  assign ack      = ack_q;
  assign abort    = abort_q;
  assign tx_send  = send_q;
  assign tx_frame = frame_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Shares one frame transmitter between `N_REQ` frame sources using round-robin arbitration. It accepts requests, latches the winning frame and issues a single-cycle send strobe. It then tracks the transmitter's ready/busy handshake and acknowledges the requester when transmission completes. It sits between the switch/frame-capture front ends and the serial transmitter, replacing direct `send` wiring when more than one source exists.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `FRAME_W`, 9: frame width in bits.
- `ACK_TIMEOUT`, 15: cycles allowed in WAIT_BUSY for the transmitter to drop `tx_ready` after `tx_send`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `req` in N_REQ: per-source request level; held high until `ack` or `abort`.
- `frame_in` in N_REQ*FRAME_W: source i's frame on bits [i*FRAME_W +: FRAME_W].
- `ack` out N_REQ: one-cycle pulse to the granted source when its frame finished.
- `abort` out N_REQ: one-cycle pulse to the granted source on timeout.
- `tx_ready` in 1: transmitter idle (high) / busy (low).
- `tx_send` out 1: one-cycle send strobe.
- `tx_frame` out FRAME_W: frame to transmit; stable from `tx_send` until the next grant.
- `grant_id` out clog2(N_REQ): index of the current/last granted source.
- `busy` out 1: high in every state except IDLE.

## Operation
- All outputs are registered. Reset values are 0: `ack`, `abort`, `tx_send`, `tx_frame`, `grant_id`, `busy`, the round-robin pointer and the timeout counter. State resets to IDLE.
- **IDLE:** when `tx_ready`=1 and `|req`:
  - choose the first set `req` bit starting at the pointer, wrapping N_REQ-1 to 0;
  - latch its frame into `tx_frame` and its index into `grant_id`;
  - go to LAUNCH.
  - If `tx_ready`=0, no grant is made and requests wait.
- **LAUNCH:** `tx_send`=1 for this cycle only; clear the counter; go to WAIT_BUSY.
- **WAIT_BUSY:**
  - If `tx_ready`=0, go to WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches ACK_TIMEOUT: pulse `abort[grant_id]`, set pointer to grant_id+1 (mod N_REQ), go to IDLE.
- **WAIT_DONE:** on `tx_ready`=1: pulse `ack[grant_id]`, set pointer to grant_id+1 (mod N_REQ), go to IDLE.
- `frame_in` and `req` are sampled only in IDLE. Changes after the grant edge have no effect on the frame in flight.
- A `req` bit that drops before it wins is simply not granted. No partial state is kept.
- A source that keeps `req` high after `ack` is re-arbitrated normally. It wins again only after the other pending sources have been served.
- Reset asserted in any state forces outputs low immediately; a frame in flight is dropped without `ack` or `abort`.

## Timing
- The grant decision is made at edge E in IDLE. `tx_send`=1 and `busy`=1 are both visible in the cycle after E. In that same cycle `tx_frame` and `grant_id` are already valid.
- Minimum request-to-strobe latency: 1 cycle. Back-to-back frames are separated by at least one IDLE cycle after `ack`.
- `ack` rises one cycle after `tx_ready` is sampled high in WAIT_DONE; `busy` falls in that same cycle.
- Timeout: `abort` fires ACK_TIMEOUT+1 cycles after the `tx_send` cycle if `tx_ready` never drops. The counter is wide enough for ACK_TIMEOUT with no wrap.
- `ack` and `abort` are never asserted together and never on more than one bit.

## Structure
- Shared package `tx_arb_pkg`:
  - state enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE};
  - default constants for N_REQ, FRAME_W, ACK_TIMEOUT;
  - a clog2 helper.
- Sub-module `rr_picker`: combinational round-robin priority selector.
  - Inputs: req vector, pointer.
  - Outputs: winner index, `valid`.
  - Reusable by other shared-resource controllers.
- Top holds the FSM, frame latch, pointer and timeout counter.

## Test plan
- Single requester: req=0001, frame0=9'h1A5, tx_ready behaves well (drops 2 cycles after send, rises 10 cycles later) -> one `tx_send` pulse, `tx_frame`=1A5, `ack`=0001 one cycle after `tx_ready` returns high.
- Contention: req=1111 held, each source re-requesting after `ack` -> grant order 0,1,2,3,0; frames match per-source values.
- Transmitter busy at request: tx_ready=0 when req=0100 rises -> no `tx_send` until tx_ready=1, then grant_id=2 the next cycle.
- Timeout: tx_ready stuck at 1 after `tx_send` -> `abort`=0001 exactly ACK_TIMEOUT+1 cycles after strobe, no `ack`, next grant goes to source 1 if pending.
- Reset mid-WAIT_DONE: rst pulsed while tx_ready=0 -> all outputs 0 immediately; after release with req=0010, grant_id=1 (pointer back at 0).
- Frame change after grant: frame_in altered in WAIT_BUSY -> `tx_frame` keeps the latched value until the next grant.
